// File: rtl/kyo_sprite_addr_gen.sv
// kyo_sprite_addr_gen: maps the VGA pixel position to a sprite ROM address with frame-latched position and stand animation
module kyo_sprite_addr_gen #(
  parameter int FRAME_W     = 48,
  parameter int FRAME_H     = 96,
  parameter int NUM_FRAMES  = 6,
  parameter int FRAME_TICKS = 6
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic        frame_start,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic        facing_left,
  input  logic        anim_enable,
  input  logic        anim_restart,
  output logic [14:0] rom_address,
  output logic        in_sprite,
  output logic [2:0]  anim_frame
);
  localparam int TW = $clog2(FRAME_TICKS + 1);
  logic [9:0]    sx, sy, mcol;
  logic          sf, hit, hit_q;
  logic [TW-1:0] tick;
  logic [10:0]   col, row;
  // Differences are 11-bit signed, so a negative offset shows up in bit 10
  always_comb begin
    col  = {1'b0, draw_x} - {1'b0, sx};
    row  = {1'b0, draw_y} - {1'b0, sy};
    hit  = !col[10] && col[9:0] < 10'(FRAME_W) && !row[10] && row[9:0] < 10'(FRAME_H);
    mcol = sf ? 10'(FRAME_W - 1) - col[9:0] : col[9:0];
  end
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      sx          <= '0;
      sy          <= '0;
      sf          <= 1'b0;
      tick        <= '0;
      anim_frame  <= '0;
      rom_address <= '0;
      hit_q       <= 1'b0;
      in_sprite   <= 1'b0;
    end else begin
      if (frame_start) begin
        sx <= pos_x;
        sy <= pos_y;
        sf <= facing_left;
      end
      if (anim_restart) begin
        tick       <= '0;
        anim_frame <= '0;
      end else if (frame_start && anim_enable) begin
        if (tick == TW'(FRAME_TICKS - 1)) begin
          tick       <= '0;
          anim_frame <= (anim_frame == 3'(NUM_FRAMES - 1)) ? 3'd0 : anim_frame + 3'd1;
        end else begin
          tick <= tick + TW'(1);
        end
      end
      rom_address <= hit ? 15'(anim_frame * FRAME_W * FRAME_H + row[9:0] * FRAME_W + mcol) : 15'd0;
      // Second hit stage lines in_sprite up with the registered RGB after the ROM read
      hit_q     <= hit;
      in_sprite <= hit_q;
    end
  end
endmodule

// File: tb/tb_kyo_sprite_addr_gen.sv
// tb_kyo_sprite_addr_gen: directed scoreboard bench for the sprite address generator
module tb_kyo_sprite_addr_gen;
  logic        vga_clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  draw_x = '0, draw_y = '0, pos_x = '0, pos_y = '0;
  logic        frame_start = 1'b0, facing_left = 1'b0, anim_enable = 1'b0, anim_restart = 1'b0;
  logic [14:0] rom_address;
  logic        in_sprite;
  logic [2:0]  anim_frame;
  int total = 0, bad = 0;
  int m_sx = 0, m_sy = 0, m_sf = 0, m_tick = 0, m_frame = 0;
  int a_q[$];
  int h_q[$];

  kyo_sprite_addr_gen dut (
    .vga_clk(vga_clk), .reset(reset), .draw_x(draw_x), .draw_y(draw_y),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .facing_left(facing_left),
    .anim_enable(anim_enable), .anim_restart(anim_restart),
    .rom_address(rom_address), .in_sprite(in_sprite), .anim_frame(anim_frame)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [9:0] x, input logic [9:0] y);
    int col, row, mc, ea, eh;
    draw_x = x;
    draw_y = y;
    col = int'(x) - m_sx;
    row = int'(y) - m_sy;
    eh  = (col >= 0 && col < 48 && row >= 0 && row < 96) ? 1 : 0;
    mc  = (m_sf != 0) ? 47 - col : col;
    ea  = (eh != 0) ? ((m_frame * 4608 + row * 48 + mc) & 32767) : 0;
    if (reset) begin
      a_q.push_back(0);
      h_q.delete();
      h_q.push_back(0);
      h_q.push_back(0);
    end else begin
      a_q.push_back(ea);
      h_q.push_back(eh);
    end
    @(posedge vga_clk);
    if (reset) begin
      m_sx = 0; m_sy = 0; m_sf = 0; m_tick = 0; m_frame = 0;
    end else begin
      if (frame_start) begin
        m_sx = int'(pos_x); m_sy = int'(pos_y); m_sf = int'(facing_left);
      end
      if (anim_restart) begin
        m_tick = 0; m_frame = 0;
      end else if (frame_start && anim_enable) begin
        if (m_tick == 5) begin
          m_tick = 0;
          m_frame = (m_frame + 1) % 6;
        end else m_tick++;
      end
    end
    @(negedge vga_clk);
    chk({tag, ".addr"}, 32'(rom_address), 32'(a_q.pop_front()));
    chk({tag, ".in"}, 32'(in_sprite), 32'(h_q.pop_front()));
    chk({tag, ".frame"}, 32'(anim_frame), 32'(m_frame));
  endtask

  task automatic pulse(input string tag);
    frame_start = 1'b1;
    step(tag, 10'd0, 10'd0);
    frame_start = 1'b0;
  endtask

  initial begin
    step("rst0", 10'd0, 10'd0);
    frame_start = 1'b1;
    step("rst1", 10'd100, 10'd50);
    frame_start = 1'b0;
    reset = 1'b0;
    pos_x = 10'd100; pos_y = 10'd50;
    pulse("latch0");
    step("org", 10'd100, 10'd50);
    step("far", 10'd147, 10'd145);
    step("flush0", 10'd0, 10'd0);
    facing_left = 1'b1;
    pulse("latch1");
    step("mir_org", 10'd100, 10'd50);
    step("mir_edge", 10'd147, 10'd50);
    step("miss_l", 10'd99, 10'd50);
    step("miss_r", 10'd148, 10'd50);
    step("miss_b", 10'd100, 10'd146);
    step("flush1", 10'd0, 10'd0);
    facing_left = 1'b0;
    anim_enable = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      pulse("anim");
      if (i == 6) chk("anim_p6", 32'(anim_frame), 32'd1);
      if (i == 30) chk("anim_p30", 32'(anim_frame), 32'd5);
      if (i == 36) chk("anim_p36", 32'(anim_frame), 32'd0);
    end
    for (int i = 0; i < 6; i++) pulse("to_f1");
    anim_enable = 1'b0;
    step("f1_org", 10'd100, 10'd50);
    pos_x = 10'd200;
    step("tear_old", 10'd100, 10'd50);
    step("tear_new", 10'd200, 10'd50);
    pulse("latch2");
    step("new_pos", 10'd200, 10'd50);
    step("flush2", 10'd0, 10'd0);
    anim_enable = 1'b1;
    for (int i = 0; i < 5; i++) pulse("to_t5");
    anim_restart = 1'b1;
    pulse("restart");
    anim_restart = 1'b0;
    chk("restart_f0", 32'(anim_frame), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      pulse("post_rst");
      if (i == 5) chk("tick_clr5", 32'(anim_frame), 32'd0);
      if (i == 6) chk("tick_clr6", 32'(anim_frame), 32'd1);
    end
    step("pre_reset", 10'd200, 10'd50);
    reset = 1'b1;
    frame_start = 1'b1;
    step("rst_fs", 10'd200, 10'd50);
    chk("rst_fs_in", 32'(in_sprite), 32'd0);
    reset = 1'b0;
    frame_start = 1'b0;
    step("after_rst", 10'd0, 10'd0);
    step("after_rst2", 10'd0, 10'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
